// File: rtl/alu_pkg.sv
// alu_pkg: opcode, one-hot index, response-error and FSM encodings shared by the ALU issue path.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    localparam int IDX_ADD = 0;
    localparam int IDX_SUB = 1;
    localparam int IDX_AND = 2;
    localparam int IDX_OR  = 3;
    localparam int IDX_SLL = 4;
    localparam int IDX_SRA = 5;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

endpackage

// File: rtl/alu_op_encoder.sv
// alu_op_encoder: one-hot operation request to 5-bit ALU opcode plus legality flag.
module alu_op_encoder
    import alu_pkg::*;
(
    input  logic [5:0] op_i,
    output logic [4:0] opcode_o,
    output logic       legal_o
);

    assign legal_o  = $onehot(op_i);
    assign opcode_o = op_i[IDX_SRA] ? OP_SRA :
                      op_i[IDX_SLL] ? OP_SLL :
                      op_i[IDX_OR]  ? OP_OR  :
                      op_i[IDX_AND] ? OP_AND :
                      op_i[IDX_SUB] ? OP_SUB : OP_ADD;

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: accepts one-hot ALU requests, drives the ALU for one op at a time,
// waits for alu_done or a timeout and returns a buffered response.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_shamt,
    output logic [4:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_shamt,
    output logic             alu_kill,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,
    output logic [1:0]       rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [4:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       err_q, err_d;
    logic [4:0]       enc_opcode;
    logic             enc_legal;

    alu_op_encoder u_enc (
        .op_i     (req_op),
        .opcode_o (enc_opcode),
        .legal_o  (enc_legal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shamt_q  <= shamt_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // ALU-facing registers only load on a legal request so a killed ALU keeps its last op.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        shamt_d  = shamt_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && enc_legal) begin
                    state_d  = S_ISSUE;
                    opcode_d = enc_opcode;
                    a_d      = req_a;
                    b_d      = req_b;
                    shamt_d  = req_shamt;
                end else if (req_valid) begin
                    state_d  = S_RESP;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = ERR_ILLEGAL;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (alu_done) begin
                    state_d  = S_RESP;
                    result_d = alu_result;
                    ovf_d    = alu_ovf;
                    err_d    = ERR_OK;
                end else if (state_q == S_ISSUE) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = state_q == S_IDLE;
    assign alu_kill   = !(state_q == S_ISSUE || state_q == S_WAIT);
    assign rsp_valid  = state_q == S_RESP;
    assign alu_opcode = opcode_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_shamt  = shamt_q;
    assign rsp_result = result_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: table-driven request vectors with a response scoreboard,
// plus hand-written reset and stray-done sequences.
module tb_alu_op_issuer;

    localparam int W  = 32;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid = 1'b0, req_ready;
    logic [5:0]    req_op = '0;
    logic [W-1:0]  req_a = '0, req_b = '0;
    logic [4:0]    req_shamt = '0;
    logic [4:0]    alu_opcode, alu_shamt;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_kill;
    logic          alu_done = 1'b0;
    logic [W-1:0]  alu_result = '0;
    logic          alu_ovf = 1'b0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_ovf;
    logic [1:0]    rsp_err;

    int total = 0, bad = 0;

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   shamt;
        int           delay;
        logic [W-1:0] res;
        logic         ovf;
        logic [4:0]   exp_opcode;
        logic [1:0]   exp_err;
        logic [W-1:0] exp_res;
        logic         exp_ovf;
        int           stall;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic [1:0]   err;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[11];

    always #5 clock = ~clock;

    alu_op_issuer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_kill(alu_kill), .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        rsp_t e;
        int lat, exp_lat;
        logic kill_ok, stable;
        logic [W-1:0] r;
        logic [1:0] er;
        logic o;
        @(negedge clock);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_shamt = v.shamt;
        sb.push_back('{v.exp_res, v.exp_ovf, v.exp_err});
        @(negedge clock);
        req_valid = 1'b0;
        if (v.exp_err == 2'b01) begin
            chk("illegal_kill", 32'(alu_kill), 32'd1);
            chk("illegal_rsp_next", 32'(rsp_valid), 32'd1);
        end else begin
            chk("opcode", 32'(alu_opcode), 32'(v.exp_opcode));
            chk("alu_a", alu_a, v.a);
            chk("alu_shamt", 32'(alu_shamt), 32'(v.shamt));
            lat = -1;
            kill_ok = 1'b1;
            exp_lat = (v.delay >= 0) ? v.delay + 1 : TO + 1;
            for (int k = 0; k < 40; k++) begin
                if (alu_kill !== 1'b0 || rsp_valid !== 1'b0) kill_ok = 1'b0;
                alu_done = (k == v.delay); alu_result = v.res; alu_ovf = v.ovf;
                @(negedge clock);
                alu_done = 1'b0;
                if (rsp_valid) begin
                    lat = k + 1;
                    break;
                end
            end
            chk("kill_low_inflight", 32'(kill_ok), 32'd1);
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("kill_in_resp", 32'(alu_kill), 32'd1);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        r = rsp_result; o = rsp_ovf; er = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clock);
            if (rsp_result !== r || rsp_ovf !== o || rsp_err !== er || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (v.stall > 0) chk("stall_stable", 32'(stable), 32'd1);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_gone", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{6'b000001, 32'd5, 32'd3, 5'd0, 2, 32'd8, 1'b0, 5'b00000, 2'b00, 32'd8, 1'b0, 0};
        vecs[1]  = '{6'b100000, 32'h8000_0000, 32'd0, 5'd4, 0, 32'hF800_0000, 1'b0, 5'b00101, 2'b00, 32'hF800_0000, 1'b0, 0};
        vecs[2]  = '{6'b000011, 32'd1, 32'd2, 5'd0, 0, 32'd0, 1'b0, 5'b00000, 2'b01, 32'd0, 1'b0, 0};
        vecs[3]  = '{6'b000000, 32'd1, 32'd2, 5'd0, 0, 32'd0, 1'b0, 5'b00000, 2'b01, 32'd0, 1'b0, 0};
        vecs[4]  = '{6'b000010, 32'd10, 32'd3, 5'd0, 1, 32'd7, 1'b0, 5'b00001, 2'b00, 32'd7, 1'b0, 5};
        vecs[5]  = '{6'b000010, 32'h8000_0000, 32'd1, 5'd0, 3, 32'h7FFF_FFFF, 1'b1, 5'b00001, 2'b00, 32'h7FFF_FFFF, 1'b1, 0};
        vecs[6]  = '{6'b000100, 32'hF0F0, 32'hFF00, 5'd0, 4, 32'hF000, 1'b0, 5'b00010, 2'b00, 32'hF000, 1'b0, 0};
        vecs[7]  = '{6'b001000, 32'hF0F0, 32'h0F0F, 5'd0, 5, 32'hFFFF, 1'b0, 5'b00011, 2'b00, 32'hFFFF, 1'b0, 2};
        vecs[8]  = '{6'b010000, 32'd1, 32'd0, 5'd7, 1, 32'h80, 1'b0, 5'b00100, 2'b00, 32'h80, 1'b0, 0};
        vecs[9]  = '{6'b000001, 32'd9, 32'd9, 5'd0, -1, 32'hDEAD_BEEF, 1'b1, 5'b00000, 2'b10, 32'd0, 1'b0, 0};
        vecs[10] = '{6'b000001, 32'd1, 32'd2, 5'd0, TO, 32'h1234, 1'b0, 5'b00000, 2'b00, 32'h1234, 1'b0, 0};

        reset_n = 1'b0;
        #2;
        chk("rst_kill", 32'(alu_kill), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run(vecs[i]);

        begin
            logic seen;
            // stray alu_done while idle must not produce a response
            @(negedge clock);
            alu_done = 1'b1; alu_result = 32'h55;
            @(negedge clock);
            alu_done = 1'b0;
            chk("idle_done_ignored", 32'(rsp_valid), 32'd0);
            // reset while waiting drops the op
            req_valid = 1'b1; req_op = 6'b000001; req_a = 32'd1; req_b = 32'd1;
            @(negedge clock);
            req_valid = 1'b0;
            @(negedge clock);
            @(negedge clock);
            chk("pre_rst_kill", 32'(alu_kill), 32'd0);
            #2 reset_n = 1'b0;
            #1;
            chk("mid_rst_kill", 32'(alu_kill), 32'd1);
            chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
            @(negedge clock);
            reset_n = 1'b1;
            alu_done = 1'b1; alu_result = 32'h99;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                alu_done = 1'b0;
                if (rsp_valid !== 1'b0) seen = 1'b1;
            end
            chk("no_stale_rsp", 32'(seen), 32'd0);
            chk("post_rst_kill", 32'(alu_kill), 32'd1);
        end

        run(vecs[0]);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
